jk_state_seq: RTL

JK_STATE_SEQ -- requirements
Module: jk_state_seq

---
 rtl/jk_pkg.sv | 10 +
 rtl/jk_hist_buf.sv | 83 ++++++++
 rtl/jk_state_seq.sv | 64 ++++++
 3 files changed

// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared defaults and history FSM state type for jk_state_seq
package jk_pkg;
  localparam int HIST_W_DEF = 8;
  localparam int CNT_W_DEF  = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } hist_state_e;
endpackage

// File: rtl/jk_hist_buf.sv
// rtl/jk_hist_buf.sv - z history shift register, sample counter and one-word output buffer
module jk_hist_buf
  import jk_pkg::*;
#(
  parameter int HIST_W = HIST_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_step,
  input  logic              i_z,
  input  logic              i_ready,
  output logic [HIST_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_ovf
);
  localparam int SC_W = (HIST_W > 1) ? $clog2(HIST_W) : 1;
  localparam logic [SC_W-1:0] LAST = SC_W'(HIST_W - 1);

  logic [HIST_W-1:0] r_shift;
  logic [SC_W-1:0]   r_scnt;
  logic [HIST_W-1:0] r_data;
  logic              r_ovf;
  hist_state_e       r_state;

  hist_state_e       w_state_nxt;
  logic [HIST_W-1:0] w_word;
  logic              w_done;
  logic              w_load;
  logic              w_drop;

  // The completed word includes the sample being taken on this edge.
  assign w_word = {r_shift[HIST_W-2:0], i_z};
  assign w_done = i_step && (r_scnt == LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= '0;
      r_scnt  <= '0;
    end else if (i_step) begin
      r_shift <= w_word;
      r_scnt  <= w_done ? '0 : r_scnt + SC_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_done) begin
          w_state_nxt = FULL;
          w_load      = 1'b1;
        end
      end
      FULL: begin
        if (i_ready) begin
          w_state_nxt = w_done ? FULL : EMPTY;
          w_load      = w_done;
        end else if (w_done) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) r_data <= w_word;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  assign o_data  = r_data;
  assign o_valid = (r_state == FULL);
  assign o_ovf   = r_ovf;
endmodule

// File: rtl/jk_state_seq.sv
// rtl/jk_state_seq.sv - JK present-state register, saturating z counter and z history stream
module jk_state_seq
  import jk_pkg::*;
#(
  parameter int HIST_W = HIST_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_ld,
  input  logic              i_ld_a,
  input  logic              i_ld_b,
  input  logic              i_aout,
  input  logic              i_bout,
  input  logic              i_z,
  input  logic              i_hist_ready,
  output logic              o_a,
  output logic              o_b,
  output logic [CNT_W-1:0]  o_z_cnt,
  output logic [HIST_W-1:0] o_hist_data,
  output logic              o_hist_valid,
  output logic              o_hist_ovf
);
  logic             r_a;
  logic             r_b;
  logic [CNT_W-1:0] r_z_cnt;
  logic             w_step;

  // A load preempts stepping, so it never samples z or touches the history.
  assign w_step = i_en && !i_ld;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_a     <= 1'b0;
      r_b     <= 1'b0;
      r_z_cnt <= '0;
    end else if (i_ld) begin
      r_a <= i_ld_a;
      r_b <= i_ld_b;
    end else if (w_step) begin
      r_a <= i_aout;
      r_b <= i_bout;
      if (i_z && (r_z_cnt != {CNT_W{1'b1}})) r_z_cnt <= r_z_cnt + CNT_W'(1);
    end
  end

  jk_hist_buf #(
    .HIST_W (HIST_W)
  ) u_hist (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_step  (w_step),
    .i_z     (i_z),
    .i_ready (i_hist_ready),
    .o_data  (o_hist_data),
    .o_valid (o_hist_valid),
    .o_ovf   (o_hist_ovf)
  );

  assign o_a     = r_a;
  assign o_b     = r_b;
  assign o_z_cnt = r_z_cnt;
endmodule
